// File: rtl/uart_transceiver.sv
// Full-duplex UART: independent TX serialiser and RX deserialiser on one clock.
// Define UART_PARITY_EN to add an even-parity bit and the rx_parity_err output.
module uart_transceiver #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_serial,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err
`ifdef UART_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      IdxLast  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------- Transmitter ----------------
  state_e          tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BitLast);
  assign tx_busy    = (tx_state_q != StIdle);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_done    = 1'b0;
    tx_serial  = 1'b1;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (tx_start) begin
          tx_shift_d = tx_data;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        tx_serial = 1'b0;
        if (tx_bit_end) tx_state_d = StData;
      end
      StData: begin
        tx_serial = tx_shift_q[tx_idx_q];
        if (tx_bit_end) begin
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == IdxLast) begin
`ifdef UART_PARITY_EN
            tx_state_d = StParity;
`else
            tx_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        tx_serial = ^tx_shift_q;
        if (tx_bit_end) tx_state_d = StStop;
      end
`endif
      StStop: begin
        if (tx_bit_end) begin
          tx_done    = 1'b1;
          tx_state_d = StIdle;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // ---------------- Receiver ----------------
  state_e          rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_done_q, rx_done_d;
  logic            rx_ferr_q, rx_ferr_d;
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic            rx_bit_end;
`ifdef UART_PARITY_EN
  logic            rx_perr_q, rx_perr_d;
  logic            rx_par_bad_q, rx_par_bad_d;
  assign rx_parity_err = rx_perr_q;
`endif

  assign rx_bit_end   = (rx_cnt_q == BitLast);
  assign rx_data      = rx_data_q;
  assign rx_done      = rx_done_q;
  assign rx_frame_err = rx_ferr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d    = 1'b0;
    rx_par_bad_d = rx_par_bad_q;
`endif
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        // Falling edge only, so a line stuck low after a bad frame stays quiet.
        if (!rx_sync2_q && rx_prev_q) rx_state_d = StStart;
      end
      StStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync2_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == IdxLast) begin
`ifdef UART_PARITY_EN
            rx_state_d = StParity;
`else
            rx_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (rx_bit_end) begin
          rx_par_bad_d = rx_sync2_q ^ (^rx_shift_q);
          rx_state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (rx_bit_end) begin
          rx_state_d = StIdle;
          if (!rx_sync2_q) begin
            rx_ferr_d = 1'b1;
`ifdef UART_PARITY_EN
          end else if (rx_par_bad_q) begin
            rx_perr_d = 1'b1;
`endif
          end else begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q    <= 1'b0;
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_sync1_q <= rx_serial;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_perr_q    <= rx_perr_d;
      rx_par_bad_q <= rx_par_bad_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: loopback and direct-drive RX, random bytes.
// Expected frames are built from the frame format; a monitor checks every RX strobe.
module tb_uart_transceiver;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  localparam int EvDone = 0;
  localparam int EvFerr = 1;
  localparam int EvPerr = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk, reset, tx_start, tx_busy, tx_done, tx_serial;
  logic       rx_serial, rx_done, rx_frame_err, loop, rx_drive;
  logic [7:0] tx_data, rx_data, last_good;
  logic       perr;
  ev_t        sb[$];
  int         vectors, miscompares, tx_frames, tx_done_cnt;

  assign rx_serial = loop ? tx_serial : rx_drive;

  uart_transceiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_serial    (tx_serial),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_frame_err (rx_frame_err)
`ifdef UART_PARITY_EN
    ,
    .rx_parity_err(perr)
`endif
  );

`ifndef UART_PARITY_EN
  assign perr = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic par_of(input logic [7:0] b);
    return 1'($countones(b) % 2);
  endfunction

  // Bits in line order: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop_b,
                                             input logic par_b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_PARITY_EN
    f[9]  = par_b;
    f[10] = stop_b;
`else
    f[9]  = stop_b;
    f[10] = par_b;
`endif
    return f;
  endfunction

  // Monitor: every RX strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    int  kind;
    ev_t e;
    kind = -1;
    if (!reset) begin
      if (rx_done) kind = EvDone;
      if (rx_frame_err) kind = EvFerr;
      if (perr) kind = EvPerr;
      if (tx_done) tx_done_cnt++;
    end
    if (kind >= 0) begin
      if (sb.size() == 0) begin
        check("rx_unexpected_event", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("rx_event_kind", 32'(kind), 32'(e.kind));
        check("rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int inject_at, input bit poke_done);
    logic [10:0] f;
    f = frame_bits(b, 1'b1, par_of(b));
    @(negedge clk);
    check("tx_idle_before_start", 32'(tx_busy), 32'd0);
    tx_data  = b;
    tx_start = 1'b1;
    sb.push_back('{EvDone, b});
    last_good = b;
    tx_frames++;
    for (int n = 1; n <= FL; n++) begin
      @(negedge clk);
      if (n == 1) tx_start = 1'b0;
      if (n == inject_at) begin
        tx_start = 1'b1;
        tx_data  = ~b;
      end
      if (n == inject_at + 1) tx_start = 1'b0;
      if (n % CPB == CPB / 2) check("tx_bit", 32'(tx_serial), 32'(f[(n-1)/CPB]));
      if (tx_done) check("tx_done_cycle", 32'(n), 32'(FL));
      if (n == FL) begin
        check("tx_done_at_frame_end", 32'(tx_done), 32'd1);
        if (poke_done) begin
          tx_start = 1'b1;
          tx_data  = 8'hEE;
        end
      end
    end
    if (poke_done) begin
      @(negedge clk);
      tx_start = 1'b0;
      check("tx_start_in_done_ignored", 32'(tx_busy), 32'd0);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                             input int hold_low);
    logic [10:0] f;
    f = frame_bits(b, stop_b, par_b);
    for (int i = 0; i < NB; i++) begin
      rx_drive = f[i];
      repeat (CPB) @(negedge clk);
    end
    repeat (hold_low) @(negedge clk);
    rx_drive = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    logic       stop_b, par_b;
    vectors = 0; miscompares = 0; tx_frames = 0; tx_done_cnt = 0;
    reset = 1'b1; loop = 1'b1; rx_drive = 1'b1; tx_start = 1'b0; tx_data = '0;
    last_good = '0;
    repeat (5) @(negedge clk);
    check("rst_tx_serial", 32'(tx_serial), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_rx_frame_err", 32'(rx_frame_err), 32'd0);
    reset = 1'b0;

    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'h12, 40, 1'b0);
    send_byte(8'h81, 0, 1'b1);
`ifdef UART_PARITY_EN
    send_byte(8'h07, 0, 1'b0);
`endif
    for (int k = 0; k < 12; k++) begin
      send_byte(8'($urandom), int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(2, FL - 1)) : 0,
                $urandom_range(0, 3) == 0);
    end
    repeat (4 * CPB) @(negedge clk);

    // Reset in the middle of a frame (data bit 0 of 0x3C is low).
    tx_data = 8'h3C; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (30) @(negedge clk);
    check("tx_low_before_reset", 32'(tx_serial), 32'd0);
    reset = 1'b1;
    #1;
    check("tx_serial_async_reset", 32'(tx_serial), 32'd1);
    check("tx_busy_async_reset", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_good = '0;
    check("rx_data_after_reset", 32'(rx_data), 32'd0);
    repeat (2 * CPB) @(negedge clk);

    // Direct RX drive.
    loop = 1'b0;
    rx_drive = 1'b0;
    repeat (5) @(negedge clk);
    rx_drive = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    sb.push_back('{EvDone, 8'h5A});
    last_good = 8'h5A;
    drive_frame(8'h5A, 1'b1, par_of(8'h5A), 0);
    sb.push_back('{EvFerr, last_good});
    drive_frame(8'hC3, 1'b0, par_of(8'hC3), 40);
    sb.push_back('{EvDone, 8'h3E});
    last_good = 8'h3E;
    drive_frame(8'h3E, 1'b1, par_of(8'h3E), 0);
`ifdef UART_PARITY_EN
    sb.push_back('{EvPerr, last_good});
    drive_frame(8'h07, 1'b1, 1'b0, 0);
`endif
    for (int k = 0; k < 10; k++) begin
      b      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = par_of(b);
`ifdef UART_PARITY_EN
      if ($urandom_range(0, 3) == 0) par_b = ~par_b;
`endif
      if (!stop_b) begin
        sb.push_back('{EvFerr, last_good});
      end else if (par_b != par_of(b)) begin
        sb.push_back('{EvPerr, last_good});
      end else begin
        sb.push_back('{EvDone, b});
        last_good = b;
      end
      drive_frame(b, stop_b, par_b, 0);
    end

    repeat (4 * CPB) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("tx_done_count", 32'(tx_done_cnt), 32'(tx_frames));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
